// File: rtl/mult_arbiter.sv
// mult_arbiter: two requesters share a single 8x8 combinational multiplier.
// A request is accepted in IDLE. The product is then computed over CALC_WAIT
// cycles in CALC and held in HOLD until the consumer takes it.
// Optional feature: define MULT_ARB_RR_EN to select round-robin arbitration.
// Without it, requester 0 has fixed priority.

module mult (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    // Widen both operands first so the full 16-bit product is kept
    assign p = {8'd0, a} * {8'd0, b};

endmodule

module mult_arbiter #(
    parameter int CALC_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    output logic        req1_ready,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_x,
    output logic        res_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [2:0] WAIT_LOAD = 3'(CALC_WAIT);

    state_t      state;
    state_t      next_state;
    logic [2:0]  cnt;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        op_id;
    logic [15:0] product;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic        capture;

    // The single shared multiplier, fed only from the latched operands
    mult u_mult (
        .a (op_a),
        .b (op_b),
        .p (product)
    );

`ifdef MULT_ARB_RR_EN
    logic ptr;

    // Round-robin pointer: after each grant, prefer the requester that was not served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~grant1;
        end
    end

    // Arbitration: the pointer settles ties, and a lone requester always wins
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = ~ptr;
            grant1 = ptr;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end
`else
    // Arbitration: requester 0 wins every tie
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        grant0 = req0_valid;
        grant1 = req1_valid && !req0_valid;
    end
`endif

    // State register; reset drops any in-flight product by returning to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and handshake outputs; ready is gated off during reset
    always_comb begin
        next_state = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        res_valid  = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (!rst) begin
                    req0_ready = grant0;
                    req1_ready = grant1;
                end
                accept = (req0_valid && req0_ready) || (req1_valid && req1_ready);
                if (accept) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                if (cnt <= 3'd1) begin
                    capture    = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: latch operands on acceptance, count down in CALC, register the product on the last CALC cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 3'd0;
            op_a   <= 8'd0;
            op_b   <= 8'd0;
            op_id  <= 1'b0;
            res_x  <= 16'h0000;
            res_id <= 1'b0;
        end else if (accept) begin
            cnt   <= WAIT_LOAD;
            op_a  <= grant1 ? req1_a : req0_a;
            op_b  <= grant1 ? req1_b : req0_b;
            op_id <= grant1;
        end else if (state == CALC) begin
            if (capture) begin
                cnt    <= 3'd0;
                res_x  <= product;
                res_id <= op_id;
            end else begin
                cnt <= cnt - 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed and random checks of mult_arbiter at CALC_WAIT=1 and 4.
// A cycle-level scoreboard model per instance is compared against the DUT at every falling edge.

module tb_mult_arbiter;

    logic        clk;
    logic        rst        [2];
    logic        req0Valid  [2];
    logic [7:0]  req0A      [2];
    logic [7:0]  req0B      [2];
    logic        req0Ready  [2];
    logic        req1Valid  [2];
    logic [7:0]  req1A      [2];
    logic [7:0]  req1B      [2];
    logic        req1Ready  [2];
    logic        resValid   [2];
    logic        resReady   [2];
    logic [15:0] resX       [2];
    logic        resId      [2];

    int checks = 0;
    int errors = 0;

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int cwOf(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    // One DUT per CALC_WAIT value, each with its own scoreboard model
    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int CW = (g == 0) ? 1 : 4;

        mult_arbiter #(.CALC_WAIT(CW)) dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req0_valid (req0Valid[g]),
            .req0_a     (req0A[g]),
            .req0_b     (req0B[g]),
            .req0_ready (req0Ready[g]),
            .req1_valid (req1Valid[g]),
            .req1_a     (req1A[g]),
            .req1_b     (req1B[g]),
            .req1_ready (req1Ready[g]),
            .res_valid  (resValid[g]),
            .res_ready  (resReady[g]),
            .res_x      (resX[g]),
            .res_id     (resId[g])
        );

        bit          inflight = 1'b0;
        int          age      = 0;
        logic [15:0] expX     = 16'h0;
        logic        expId    = 1'b0;
        bit          prefer   = 1'b0;
        bit          any;
        bit          pick;
        bit          expValid;

        // Scoreboard: a transaction is owed from acceptance, and the product must appear after CW+1 edges
        always @(negedge clk) begin
            if (rst[g]) begin
                check($sformatf("i%0d_rst_ready0", g), 32'(req0Ready[g]), 32'd0);
                check($sformatf("i%0d_rst_ready1", g), 32'(req1Ready[g]), 32'd0);
                check($sformatf("i%0d_rst_valid", g), 32'(resValid[g]), 32'd0);
                check($sformatf("i%0d_rst_x", g), 32'(resX[g]), 32'd0);
                check($sformatf("i%0d_rst_id", g), 32'(resId[g]), 32'd0);
                inflight = 1'b0;
                age      = 0;
                prefer   = 1'b0;
            end else if (!inflight) begin
                any  = req0Valid[g] || req1Valid[g];
                pick = 1'b0;
                if (req0Valid[g] && req1Valid[g]) begin
`ifdef MULT_ARB_RR_EN
                    pick = prefer;
`else
                    pick = 1'b0;
`endif
                end else begin
                    pick = req1Valid[g];
                end
                check($sformatf("i%0d_ready0", g), 32'(req0Ready[g]), 32'(any && !pick));
                check($sformatf("i%0d_ready1", g), 32'(req1Ready[g]), 32'(any && pick));
                check($sformatf("i%0d_idle_valid", g), 32'(resValid[g]), 32'd0);
                if (any) begin
                    inflight = 1'b1;
                    age      = 0;
                    expId    = pick;
                    expX     = pick ? {8'd0, req1A[g]} * {8'd0, req1B[g]}
                                    : {8'd0, req0A[g]} * {8'd0, req0B[g]};
                    prefer   = ~pick;
                end
            end else begin
                check($sformatf("i%0d_busy_ready0", g), 32'(req0Ready[g]), 32'd0);
                check($sformatf("i%0d_busy_ready1", g), 32'(req1Ready[g]), 32'd0);
                age++;
                expValid = (age > CW);
                check($sformatf("i%0d_valid", g), 32'(resValid[g]), 32'(expValid));
                if (expValid) begin
                    check($sformatf("i%0d_x", g), 32'(resX[g]), 32'(expX));
                    check($sformatf("i%0d_id", g), 32'(resId[g]), 32'(expId));
                    if (resReady[g]) begin
                        inflight = 1'b0;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input int k, input bit v0, input logic [7:0] a0, input logic [7:0] b0,
                                 input bit v1, input logic [7:0] a1, input logic [7:0] b1);
        req0Valid[k] = v0;
        req0A[k]     = a0;
        req0B[k]     = b0;
        req1Valid[k] = v1;
        req1A[k]     = a1;
        req1B[k]     = b1;
    endtask

    task automatic waitHandshake(input int k, input bit r, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (r ? req1Ready[k] : req0Ready[k]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitValid(input int k, output int edges, output bit ok);
        ok    = 1'b0;
        edges = 1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (resValid[k]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One full transaction; operands are scrambled right after acceptance
    task automatic checkOutput(input int k, input bit r, input logic [7:0] a, input logic [7:0] b,
                               input bit both, input logic [15:0] expX, input bit expId);
        bit ok;
        int edges;
        resReady[k] = 1'b1;
        applyStimulus(k, (r == 1'b0) || both, a, b, (r == 1'b1) || both, a, b);
        waitHandshake(k, r, ok);
        check($sformatf("i%0d_handshake_timeout", k), 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(k, 1'b0, 8'($urandom), 8'($urandom), 1'b0, 8'($urandom), 8'($urandom));
        if (!ok) return;
        waitValid(k, edges, ok);
        check($sformatf("i%0d_result_timeout", k), 32'(ok), 32'd1);
        if (!ok) return;
        check($sformatf("i%0d_latency", k), 32'(edges), 32'(cwOf(k) + 1));
        check($sformatf("i%0d_res_x", k), 32'(resX[k]), 32'(expX));
        check($sformatf("i%0d_res_id", k), 32'(resId[k]), 32'(expId));
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset(input int k);
        @(posedge clk);
        #1;
        rst[k] = 1'b1;
        applyStimulus(k, 1'b1, 8'd5, 8'd6, 1'b1, 8'd7, 8'd8);
        @(negedge clk);
        check($sformatf("i%0d_reset_ready0", k), 32'(req0Ready[k]), 32'd0);
        check($sformatf("i%0d_reset_ready1", k), 32'(req1Ready[k]), 32'd0);
        check($sformatf("i%0d_reset_valid", k), 32'(resValid[k]), 32'd0);
        check($sformatf("i%0d_reset_x", k), 32'(resX[k]), 32'h0000);
        @(posedge clk);
        #1;
        rst[k] = 1'b0;
        applyStimulus(k, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic runDirected(input int k);
        bit ok;
        int seen;
        int expOrder [4];
        logic [15:0] heldX;
        logic heldId;

        pulseReset(k);

        checkOutput(k, 1'b0, 8'd12, 8'd13, 1'b0, 16'd156, 1'b0);
        checkOutput(k, 1'b0, 8'd0, 8'd255, 1'b0, 16'd0, 1'b0);
        checkOutput(k, 1'b1, 8'd255, 8'd255, 1'b0, 16'hFE01, 1'b1);
        checkOutput(k, 1'b1, 8'd1, 8'd1, 1'b0, 16'd1, 1'b1);

        // Contention from a freshly reset pointer
        pulseReset(k);
`ifdef MULT_ARB_RR_EN
        expOrder = '{0, 1, 0, 1};
`else
        expOrder = '{0, 0, 0, 0};
`endif
        resReady[k] = 1'b1;
        applyStimulus(k, 1'b1, 8'd2, 8'd3, 1'b1, 8'd4, 8'd5);
        for (int n = 0; n < 4; n++) begin
            ok   = 1'b0;
            seen = -1;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (req0Ready[k] || req1Ready[k]) begin
                    ok   = 1'b1;
                    seen = req1Ready[k] ? 1 : 0;
                    break;
                end
            end
            check($sformatf("i%0d_contention_timeout", k), 32'(ok), 32'd1);
            check($sformatf("i%0d_grant_order%0d", k, n), 32'(seen), 32'(expOrder[n]));
            @(posedge clk);
            #1;
        end
        applyStimulus(k, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        repeat (8) @(posedge clk);
        #1;

        // Back-pressure: five cycles in HOLD with both requesters knocking
        resReady[k] = 1'b0;
        applyStimulus(k, 1'b1, 8'd20, 8'd30, 1'b0, 8'd0, 8'd0);
        waitHandshake(k, 1'b0, ok);
        check($sformatf("i%0d_bp_handshake", k), 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(k, 1'b0, 8'd99, 8'd99, 1'b0, 8'd0, 8'd0);
        waitValid(k, seen, ok);
        check($sformatf("i%0d_bp_valid", k), 32'(ok), 32'd1);
        heldX  = 16'd600;
        heldId = 1'b0;
        applyStimulus(k, 1'b1, 8'd9, 8'd9, 1'b1, 8'd8, 8'd8);
        repeat (5) begin
            @(negedge clk);
            check($sformatf("i%0d_bp_x", k), 32'(resX[k]), 32'(heldX));
            check($sformatf("i%0d_bp_id", k), 32'(resId[k]), 32'(heldId));
            check($sformatf("i%0d_bp_ready0", k), 32'(req0Ready[k]), 32'd0);
            check($sformatf("i%0d_bp_ready1", k), 32'(req1Ready[k]), 32'd0);
            @(posedge clk);
            #1;
        end
        applyStimulus(k, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        resReady[k] = 1'b1;
        @(negedge clk);
        check($sformatf("i%0d_bp_release_valid", k), 32'(resValid[k]), 32'd1);
        @(negedge clk);
        check($sformatf("i%0d_bp_after_valid", k), 32'(resValid[k]), 32'd0);
        @(posedge clk);
        #1;

        // Reset while (7,9) is being computed
        applyStimulus(k, 1'b0, 8'd0, 8'd0, 1'b1, 8'd7, 8'd9);
        waitHandshake(k, 1'b1, ok);
        check($sformatf("i%0d_midcalc_handshake", k), 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        applyStimulus(k, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        rst[k] = 1'b1;
        @(negedge clk);
        check($sformatf("i%0d_midcalc_valid", k), 32'(resValid[k]), 32'd0);
        check($sformatf("i%0d_midcalc_x", k), 32'(resX[k]), 32'h0000);
        @(posedge clk);
        #1;
        rst[k] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check($sformatf("i%0d_postreset_valid", k), 32'(resValid[k]), 32'd0);
            check($sformatf("i%0d_postreset_x", k), 32'(resX[k]), 32'h0000);
        end
        @(posedge clk);
        #1;
        checkOutput(k, 1'b0, 8'd3, 8'd4, 1'b1, 16'd12, 1'b0);
    endtask

    task automatic randomSweep(input int k, input int count);
        bit r;
        logic [7:0] a;
        logic [7:0] b;
        for (int n = 0; n < count; n++) begin
            r = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = 8'($urandom);
            checkOutput(k, r, a, b, 1'b0, {8'd0, a} * {8'd0, b}, r);
        end
    endtask

    // Main sequence: reset, directed tests per instance, then a parallel random sweep
    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k]      = 1'b1;
            resReady[k] = 1'b1;
            applyStimulus(k, 1'b0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        $display("[TB] directed tests, CALC_WAIT=1");
        runDirected(0);
        $display("[TB] directed tests, CALC_WAIT=4");
        runDirected(1);

        $display("[TB] random sweep");
        fork
            randomSweep(0, 5000);
            randomSweep(1, 5000);
        join

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
